if_id_stage_buffer: RTL and testbench

- Parametrised fetch→decode pipeline stage for the RV32 pipeline.
- Replaces the plain always-load IF/ID register with a valid/ready handshake stage: stall back-pressure, synchronous flush with NOP injection, and a saturating stall counter.
- Sits between the fetch unit (PC + instruction memory) and the decoder / register-file read stage.

---
 rtl/if_id_stage_buffer.sv | 146 ++++++++++++++
 tb/tb_if_id_stage_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_buffer.sv
// IF/ID pipeline stage: valid/ready handshake register with flush (NOP injection) and a saturating stall counter.
// Build option IF_ID_SKID_EN adds a one-entry skid buffer so in_ready has no combinational path from out_ready.
//
// state | meaning
// EMPTY | no beat held; out_instr shows NOP_INSTR
// FULL  | main register holds the beat presented to decode
// SKID  | main register plus skid entry both hold beats (IF_ID_SKID_EN only)
module if_id_stage_buffer #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ILEN-1:0]  in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_plus4,
    output logic [ILEN-1:0]  out_instr,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc4_q;
    logic [ILEN-1:0]  instr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_xfer;
    logic             accept;

`ifdef IF_ID_SKID_EN
    logic [XLEN-1:0]  skid_pc_q;
    logic [ILEN-1:0]  skid_instr_q;

    // Depends only on state: upstream never sees out_ready combinationally.
    assign in_ready = (state_q != SKID);
`else
    assign in_ready = (state_q == EMPTY) || out_ready;
`endif

    assign out_valid    = (state_q != EMPTY);
    assign out_pc       = pc_q;
    assign out_pc_plus4 = pc4_q;
    assign out_instr    = instr_q;
    assign stall_cnt    = cnt_q;

    assign out_xfer = out_valid && out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= EMPTY;
            pc_q         <= '0;
            pc4_q        <= '0;
            instr_q      <= NOP_INSTR;
`ifdef IF_ID_SKID_EN
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
`endif
        end else if (flush) begin
            state_q <= EMPTY;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        pc_q    <= in_pc;
                        pc4_q   <= in_pc + XLEN'(4);
                        instr_q <= in_instr;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        if (accept) begin
                            pc_q    <= in_pc;
                            pc4_q   <= in_pc + XLEN'(4);
                            instr_q <= in_instr;
                        end else begin
                            state_q <= EMPTY;
                            instr_q <= NOP_INSTR;
                        end
                    end
`ifdef IF_ID_SKID_EN
                    else if (accept) begin
                        state_q      <= SKID;
                        skid_pc_q    <= in_pc;
                        skid_instr_q <= in_instr;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                SKID: begin
                    if (out_xfer) begin
                        state_q <= FULL;
                        pc_q    <= skid_pc_q;
                        pc4_q   <= skid_pc_q + XLEN'(4);
                        instr_q <= skid_instr_q;
                    end
                end
`endif
                default: begin
                    state_q <= EMPTY;
                    instr_q <= NOP_INSTR;
                end
            endcase
        end
    end

    // Flush intentionally leaves the counter alone; only clear or reset zero it.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Scoreboard bench for if_id_stage_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_if_id_stage_buffer;

    localparam int          CW      = 4;
    localparam int          CNT_SAT = 15;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_plus4;
    logic [31:0]   out_instr;
    logic [CW-1:0] stall_cnt;
    logic          stall_cnt_clr;

    if_id_stage_buffer #(
        .XLEN      (32),
        .ILEN      (32),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .out_instr     (out_instr),
        .stall_cnt     (stall_cnt),
        .stall_cnt_clr (stall_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    // Beats currently held by the stage, oldest first.
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mdl_cnt = 0;
    bit    mdl_in_ready = 1'b1;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the model and retires beats decode consumes.
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef IF_ID_SKID_EN
            mdl_in_ready = (exp_q.size() < 2);
`else
            mdl_in_ready = (exp_q.size() == 0) || out_ready;
`endif
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, mdl_in_ready});
            chk("stall_cnt", 32'(stall_cnt), 32'(mdl_cnt));
            if (exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_pc_plus4", out_pc_plus4, exp_q[0].pc + 32'd4);
                chk("out_instr", out_instr, exp_q[0].instr);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("out_instr_nop", out_instr, NOP);
            end
        end
    end

    // Drives one cycle of stimulus (called at posedge+1) and updates the model at the edge.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                        input bit ordy, input bit fl, input bit clr, output bit acc);
        int held;
        in_valid      = v;
        in_pc         = pc;
        in_instr      = ins;
        out_ready     = ordy;
        flush         = fl;
        stall_cnt_clr = clr;
        held          = exp_q.size();
        @(posedge clk);
        if (clr) mdl_cnt = 0;
        else if (held > 0 && !ordy && mdl_cnt < CNT_SAT) mdl_cnt++;
        acc = v && mdl_in_ready && !fl;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back({pc, ins});
        #1;
    endtask

    task automatic idle(input bit ordy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_pc4"}, out_pc_plus4, 32'd0);
        chk({tag, "_instr"}, out_instr, NOP);
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    logic [31:0] stream_pc[3];
    logic [31:0] stream_in[3];

    initial begin
        bit          acc;
        logic [31:0] pc;
        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0; stall_cnt_clr = 1'b0;
        stream_pc = '{32'h0, 32'h4, 32'h8};
        stream_in = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};

        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream with decode always ready.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, stream_pc[i], stream_in[i], 1'b1, 1'b0, 1'b0, acc);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc", out_pc, stream_pc[i]);
            chk("stream_pc4", out_pc_plus4, stream_pc[i] + 32'd4);
        end
        idle(1'b1, 2);

        // Three-cycle decode stall on PC 0x10 with fetch still offering beats.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        step(1'b1, 32'h10, 32'h0000_0463, 1'b1, 1'b0, 1'b0, acc);
        pc = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pc, pc ^ 32'h0000_0093, 1'b0, 1'b0, 1'b0, acc);
            if (acc) pc += 32'd4;
            chk("stall_hold_pc", out_pc, 32'h10);
        end
        chk("stall_cnt_3", 32'(stall_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pc, pc ^ 32'h0000_0093, 1'b1, 1'b0, 1'b0, acc);
            if (acc) pc += 32'd4;
        end
        idle(1'b1, 3);

        // Flush while holding PC 0x20 with PC 0x24 on the input.
        step(1'b1, 32'h20, 32'h0000_0033, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 32'h24, 32'h0000_0133, 1'b0, 1'b1, 1'b0, acc);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_instr", out_instr, NOP);
        chk("flush_pc", out_pc, 32'd0);
        chk("flush_pc4", out_pc_plus4, 32'd0);
        idle(1'b1, 2);

        // PC wrap on the +4 path.
        step(1'b1, 32'hFFFF_FFFC, 32'h0000_0233, 1'b1, 1'b0, 1'b0, acc);
        chk("wrap_pc4", out_pc_plus4, 32'h0);
        idle(1'b1, 1);

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 32'h40, 32'h0000_0333, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        #2;
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        mdl_cnt = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;
        chk("in_ready_after_async", {31'd0, in_ready}, 32'd1);
        step(1'b1, 32'h50, 32'h0000_0433, 1'b1, 1'b0, 1'b0, acc);
        chk("post_rst_pc", out_pc, 32'h50);
        idle(1'b1, 1);

        // Counter saturation and clear priority.
        step(1'b1, 32'h60, 32'h0000_0533, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b0, 20);
        chk("stall_sat", 32'(stall_cnt), 32'(CNT_SAT));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        chk("stall_clr", 32'(stall_cnt), 32'd0);
        idle(1'b1, 2);

        // Randomized traffic.
        pc = 32'h1000;
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 9) < 7, pc, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 31) == 0, acc);
            if (acc) pc += 32'd4;
        end
        idle(1'b1, 3);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
